// File: rtl/tmds_video_sequencer.sv
// Raster timing sequencer feeding the R/G/B TMDS encoders: counters, fetch requests, LEAD-delayed output stage.
// Optional colour-bar test pattern is enabled by defining TMDS_SEQ_TPG_EN.
//
// state  | meaning
// IDLE   | counters held at (0,0), no requests
// RUN    | raster counting, stops at frame end once en drops
// DRAIN  | en dropped mid-frame; finish the frame, then IDLE
module tmds_video_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        tpg_sel,
    output logic        req_valid,
    output logic [11:0] req_x,
    output logic [11:0] req_y,
    input  logic [23:0] pix_in,
    output logic        active_out,
    output logic [1:0]  ctl_r,
    output logic [1:0]  ctl_g,
    output logic [1:0]  ctl_b,
    output logic [7:0]  pdata_r,
    output logic [7:0]  pdata_g,
    output logic [7:0]  pdata_b,
    output logic        frame_start,
    output logic        line_start,
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [11:0] h_nx, v_nx;
    logic        frame_last;
    logic        req_valid_q, req_valid_d;
    logic [11:0] req_x_q, req_x_d, req_y_q, req_y_d;

    // Per-stage flag bundle: {frame_start, line_start, active, vsync, hsync}
    logic [4:0]  flg_now;
    logic [4:0]  flg_q [LEAD];
    logic [4:0]  flg_d [LEAD];
    logic [4:0]  flg_out;
    logic        counting;

    logic        active_q, active_d;
    logic [1:0]  ctl_b_q, ctl_b_d;
    logic [23:0] pdata_q, pdata_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q, line_start_d;
    logic [23:0] pix_sel;

`ifdef TMDS_SEQ_TPG_EN
    logic [11:0] x_q [LEAD];
    logic [11:0] x_d [LEAD];
    logic [14:0] tpg_prod;
    logic [2:0]  tpg_bar;
`else
    logic        unused_tpg_sel;
    assign unused_tpg_sel = tpg_sel;
`endif

    assign frame_last = (h_q == H_LAST) && (v_q == V_LAST);
    assign h_nx       = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
    assign v_nx       = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? 12'd0 : v_q + 12'd1);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                h_d = 12'd0;
                v_d = 12'd0;
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                h_d = h_nx;
                v_d = v_nx;
                if (!en) state_d = frame_last ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                h_d = h_nx;
                v_d = v_nx;
                if (frame_last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                h_d     = 12'd0;
                v_d     = 12'd0;
            end
        endcase
        // Requests are registered from the next counter value so they line up with h_q/v_q
        req_valid_d = (state_d != S_IDLE) && (h_d < H_ACT) && (v_d < V_ACT);
        req_x_d     = req_valid_d ? h_d : 12'd0;
        req_y_d     = req_valid_d ? v_d : 12'd0;
    end

    assign counting = (state_q != S_IDLE);

    always_comb begin
        flg_now[0] = counting && (h_q >= HS_BEG) && (h_q < HS_END);
        flg_now[1] = counting && (v_q >= VS_BEG) && (v_q < VS_END);
        flg_now[2] = req_valid_q;
        flg_now[3] = counting && (h_q == 12'd0);
        flg_now[4] = counting && (h_q == 12'd0) && (v_q == 12'd0);
        flg_d[0]   = flg_now;
        for (int i = 1; i < LEAD; i++) flg_d[i] = flg_q[i-1];
`ifdef TMDS_SEQ_TPG_EN
        x_d[0] = req_x_q;
        for (int i = 1; i < LEAD; i++) x_d[i] = x_q[i-1];
`endif
    end

    assign flg_out = flg_q[LEAD-1];

`ifdef TMDS_SEQ_TPG_EN
    assign tpg_prod = {x_q[LEAD-1], 3'b000};
    assign tpg_bar  = 3'(tpg_prod / 15'(H_ACTIVE));
`endif

    always_comb begin
        pix_sel = pix_in;
`ifdef TMDS_SEQ_TPG_EN
        // Bar 0 is white, bar 7 black: each colour byte is on when its bar bit is clear
        if (tpg_sel) pix_sel = {{8{~tpg_bar[2]}}, {8{~tpg_bar[1]}}, {8{~tpg_bar[0]}}};
`endif
        active_d      = flg_out[2];
        pdata_d       = flg_out[2] ? pix_sel : 24'h0;
        ctl_b_d       = {flg_out[1] ~^ VS_POL, flg_out[0] ~^ HS_POL};
        frame_start_d = flg_out[4];
        line_start_d  = flg_out[3];
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            req_valid_q   <= 1'b0;
            req_x_q       <= 12'd0;
            req_y_q       <= 12'd0;
            for (int i = 0; i < LEAD; i++) flg_q[i] <= 5'd0;
`ifdef TMDS_SEQ_TPG_EN
            for (int i = 0; i < LEAD; i++) x_q[i] <= 12'd0;
`endif
            active_q      <= 1'b0;
            ctl_b_q       <= {~VS_POL, ~HS_POL};
            pdata_q       <= 24'h0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            req_valid_q   <= req_valid_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            for (int i = 0; i < LEAD; i++) flg_q[i] <= flg_d[i];
`ifdef TMDS_SEQ_TPG_EN
            for (int i = 0; i < LEAD; i++) x_q[i] <= x_d[i];
`endif
            active_q      <= active_d;
            ctl_b_q       <= ctl_b_d;
            pdata_q       <= pdata_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign active_out  = active_q;
    assign ctl_r       = 2'b00;
    assign ctl_g       = 2'b00;
    assign ctl_b       = ctl_b_q;
    assign pdata_r     = pdata_q[23:16];
    assign pdata_g     = pdata_q[15:8];
    assign pdata_b     = pdata_q[7:0];
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign running     = counting;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Directed bench for tmds_video_sequencer on a 12x6 raster with LEAD=2, active-low syncs.
module tb_tmds_video_sequencer;

    logic        pixel_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        tpg_sel = 1'b0;
    logic        req_valid;
    logic [11:0] req_x, req_y;
    logic [23:0] pix_in = 24'h0;
    logic        active_out;
    logic [1:0]  ctl_r, ctl_g, ctl_b;
    logic [7:0]  pdata_r, pdata_g, pdata_b;
    logic        frame_start, line_start, running;

    int n_chk = 0;
    int n_pass = 0;

    logic [11:0] rx_d1 = 12'd0, rx_d2 = 12'd0, ry_d1 = 12'd0, ry_d2 = 12'd0;

    localparam logic [32:0] OUT_IDLE = {1'b0, 2'b00, 2'b00, 2'b11, 24'h0, 1'b0, 1'b0};

    tmds_video_sequencer #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .en         (en),
        .tpg_sel    (tpg_sel),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .pix_in     (pix_in),
        .active_out (active_out),
        .ctl_r      (ctl_r),
        .ctl_g      (ctl_g),
        .ctl_b      (ctl_b),
        .pdata_r    (pdata_r),
        .pdata_g    (pdata_g),
        .pdata_b    (pdata_b),
        .frame_start(frame_start),
        .line_start (line_start),
        .running    (running)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Pixel source: returns {x, y, 5A} for the request seen two cycles earlier
    always @(negedge pixel_clk) begin
        pix_in = {rx_d2[7:0], ry_d2[7:0], 8'h5A};
        rx_d2  = rx_d1;
        ry_d2  = ry_d1;
        rx_d1  = req_x;
        ry_d1  = req_y;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [32:0] obs_out();
        return {active_out, ctl_r, ctl_g, ctl_b, pdata_r, pdata_g, pdata_b, frame_start, line_start};
    endfunction

    function automatic logic [25:0] obs_req();
        return {running, req_valid, req_x, req_y};
    endfunction

    // Expected request side for raster position index p (p<0: idle)
    function automatic logic [25:0] exp_req(int p);
        int h, v;
        if (p < 0) return 26'h0;
        h = (p % 72) % 12;
        v = (p % 72) / 12;
        if (h < 8 && v < 3) return {1'b1, 1'b1, 12'(h), 12'(v)};
        return {1'b1, 1'b0, 24'h0};
    endfunction

    // Expected output stage for raster position index m (m<0: idle)
    function automatic logic [32:0] exp_out(int m, bit tpg);
        int h, v;
        logic act;
        logic [23:0] pix;
        logic [1:0] cb;
        if (m < 0) return OUT_IDLE;
        h   = (m % 72) % 12;
        v   = (m % 72) / 12;
        act = (h < 8 && v < 3);
        cb  = {!(v == 4), !(h == 9 || h == 10)};
        pix = 24'h0;
        if (act) begin
            if (tpg) begin
                case (h)
                    0: pix = 24'hFFFFFF;
                    1: pix = 24'hFFFF00;
                    2: pix = 24'hFF00FF;
                    3: pix = 24'hFF0000;
                    4: pix = 24'h00FFFF;
                    5: pix = 24'h00FF00;
                    6: pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end else begin
                pix = {8'(h), 8'(v), 8'h5A};
            end
        end
        return {act, 2'b00, 2'b00, cb, pix, (h == 0 && v == 0), (h == 0)};
    endfunction

    initial begin
        bit use_tpg;
        use_tpg = 1'b0;

        // Reset and idle with en low
        repeat (3) @(negedge pixel_clk);
        chk("rst_out", obs_out(), OUT_IDLE);
        chk("rst_req", obs_req(), 26'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge pixel_clk);
            chk($sformatf("idle_req k=%0d", k), obs_req(), 26'h0);
            chk($sformatf("idle_out k=%0d", k), obs_out(), OUT_IDLE);
        end

        // Two frames; en drops at (3,1) of the second, which drains to (11,5)
        en = 1'b1;
        for (int k = 0; k <= 152; k++) begin
            @(negedge pixel_clk);
            chk($sformatf("req k=%0d", k), obs_req(), exp_req(k <= 143 ? k : -1));
            chk($sformatf("out k=%0d", k), obs_out(),
                exp_out((k - 3 >= 0 && k - 3 <= 143) ? k - 3 : -1, 1'b0));
            if (k == 87) en = 1'b0;
        end

        // Asynchronous reset mid-line during active output
`ifdef TMDS_SEQ_TPG_EN
        tpg_sel = 1'b1;
        use_tpg = 1'b1;
`endif
        en = 1'b1;
        for (int k = 0; k <= 5; k++) @(negedge pixel_clk);
        chk("pre_rst_active", {31'h0, active_out}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", obs_out(), OUT_IDLE);
        chk("async_rst_req", obs_req(), 26'h0);
        @(negedge pixel_clk);
        chk("held_rst_out", obs_out(), OUT_IDLE);
        rst_n = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge pixel_clk);
            chk($sformatf("rerun_req k=%0d", k), obs_req(), exp_req(k));
            chk($sformatf("rerun_out k=%0d", k), obs_out(), exp_out(k - 3, use_tpg));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
